// File: rtl/pe_conv_ctrl.sv
// Sequences one external MAC through a row-stationary 1-D convolution. Define PE_CTRL_ZERO_SKIP_EN
// to drop mac_en on zero activations after the first tap of each window.
module pe_conv_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FILT_MAX  = 8,
  parameter int unsigned IFMAP_MAX = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(FILT_MAX):0]     filt_len,
  input  logic [$clog2(IFMAP_MAX):0]    ifmap_len,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [DATA_W-1:0]             w_data,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [DATA_W-1:0]             a_data,
  input  logic                          pin_valid,
  output logic                          pin_ready,
  input  logic [DATA_W-1:0]             pin_data,
  output logic                          pout_valid,
  input  logic                          pout_ready,
  output logic [DATA_W-1:0]             pout_data,
  output logic [DATA_W-1:0]             mac_a,
  output logic [DATA_W-1:0]             mac_w,
  output logic [DATA_W-1:0]             mac_sum,
  output logic                          mac_en,
  input  logic [2*DATA_W-1:0]           mac_out,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int unsigned FLEN_W = $clog2(FILT_MAX) + 1;
  localparam int unsigned ILEN_W = $clog2(IFMAP_MAX) + 1;
  localparam int unsigned WIDX_W = (FILT_MAX > 1) ? $clog2(FILT_MAX) : 1;
  localparam int unsigned AIDX_W = (IFMAP_MAX > 1) ? $clog2(IFMAP_MAX) : 1;

  localparam logic [FLEN_W-1:0] F_ONE       = FLEN_W'(1);
  localparam logic [ILEN_W-1:0] I_ONE       = ILEN_W'(1);
  localparam logic [FLEN_W-1:0] FILT_MAX_L  = FLEN_W'(FILT_MAX);
  localparam logic [ILEN_W-1:0] IFMAP_MAX_L = ILEN_W'(IFMAP_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_PSUM_WAIT,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [FLEN_W-1:0] filt_len_q;
  logic [ILEN_W-1:0] ifmap_len_q;
  logic [ILEN_W-1:0] cnt_q;
  logic [FLEN_W-1:0] tap_q;
  logic [ILEN_W-1:0] win_q;
  logic [DATA_W-1:0] psum_q;

  logic [DATA_W-1:0] wspad [FILT_MAX];
  logic [DATA_W-1:0] aspad [IFMAP_MAX];

  logic              cfg_ok;
  logic              w_hs, a_hs, pin_hs, pout_hs;
  logic              w_last, a_last, tap_last, win_last;
  logic [ILEN_W-1:0] n_win;
  logic [ILEN_W-1:0] a_idx;
  logic [DATA_W-1:0] a_sel, w_sel;
  logic              unused_bits;

  // A start is legal when 1 <= S <= FILT_MAX and S <= W <= IFMAP_MAX.
  assign cfg_ok = (filt_len != '0) && (filt_len <= FILT_MAX_L) &&
                  (ifmap_len <= IFMAP_MAX_L) && (ifmap_len >= ILEN_W'(filt_len));

  assign n_win    = ifmap_len_q - ILEN_W'(filt_len_q) + I_ONE;
  assign w_last   = (cnt_q == ILEN_W'(filt_len_q) - I_ONE);
  assign a_last   = (cnt_q == ifmap_len_q - I_ONE);
  assign tap_last = (tap_q == filt_len_q - F_ONE);
  assign win_last = ((win_q + I_ONE) == n_win);

  assign a_idx = win_q + ILEN_W'(tap_q);
  assign a_sel = aspad[a_idx[AIDX_W-1:0]];
  assign w_sel = wspad[tap_q[WIDX_W-1:0]];

  // Psums are modulo 2^DATA_W, so the MAC's upper result bits are never consumed.
  assign unused_bits = ^{mac_out[2*DATA_W-1:DATA_W], a_idx[ILEN_W-1:AIDX_W]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake strobes and decoded outputs.
  always_comb begin
    state_d    = state_q;
    w_ready    = 1'b0;
    a_ready    = 1'b0;
    pin_ready  = 1'b0;
    pout_valid = 1'b0;
    pout_data  = '0;
    mac_en     = 1'b0;
    mac_a      = '0;
    mac_w      = '0;
    mac_sum    = '0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    w_hs       = 1'b0;
    a_hs       = 1'b0;
    pin_hs     = 1'b0;
    pout_hs    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        w_hs    = w_valid;
        if (w_valid && w_last) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        a_ready = 1'b1;
        a_hs    = a_valid;
        if (a_valid && a_last) state_d = S_PSUM_WAIT;
      end
      S_PSUM_WAIT: begin
        pin_ready = 1'b1;
        pin_hs    = pin_valid;
        if (pin_valid) state_d = S_MAC;
      end
      S_MAC: begin
        mac_a   = a_sel;
        mac_w   = w_sel;
        mac_sum = (tap_q == '0) ? psum_q : mac_out[DATA_W-1:0];
`ifdef PE_CTRL_ZERO_SKIP_EN
        // Tap 0 must always issue to load the incoming psum into the chain.
        mac_en  = (tap_q == '0) || (a_sel != '0);
`else
        mac_en  = 1'b1;
`endif
        if (tap_last) state_d = S_EMIT;
      end
      S_EMIT: begin
        pout_valid = 1'b1;
        pout_data  = mac_out[DATA_W-1:0];
        pout_hs    = pout_ready;
        if (pout_ready) state_d = win_last ? S_DONE : S_PSUM_WAIT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lengths, load/tap/window counters, latched psum and sticky config error.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_len_q  <= '0;
      ifmap_len_q <= '0;
      cnt_q       <= '0;
      tap_q       <= '0;
      win_q       <= '0;
      psum_q      <= '0;
      cfg_err     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        cfg_err <= !cfg_ok;
        if (cfg_ok) begin
          filt_len_q  <= filt_len;
          ifmap_len_q <= ifmap_len;
          cnt_q       <= '0;
          win_q       <= '0;
        end
      end
      if (w_hs) cnt_q <= w_last ? '0 : cnt_q + I_ONE;
      if (a_hs) cnt_q <= a_last ? '0 : cnt_q + I_ONE;
      if (pin_hs) begin
        psum_q <= pin_data;
        tap_q  <= '0;
      end
      if (state_q == S_MAC) tap_q <= tap_q + F_ONE;
      if (pout_hs) win_q <= win_q + I_ONE;
    end
  end

  // Scratchpads carry no reset; contents are only read after being loaded.
  always_ff @(posedge clk) begin
    if (w_hs) wspad[cnt_q[WIDX_W-1:0]] <= w_data;
    if (a_hs) aspad[cnt_q[AIDX_W-1:0]] <= a_data;
  end

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Bench for pe_conv_ctrl: behavioural MAC, window-sum reference model, directed and random runs.
module tb_pe_conv_ctrl;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FILT_MAX  = 8;
  localparam int unsigned IFMAP_MAX = 32;
  localparam int unsigned FLEN_W    = $clog2(FILT_MAX) + 1;
  localparam int unsigned ILEN_W    = $clog2(IFMAP_MAX) + 1;
`ifdef PE_CTRL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                start;
  logic [FLEN_W-1:0]   filt_len;
  logic [ILEN_W-1:0]   ifmap_len;
  logic                w_valid, w_ready;
  logic [DATA_W-1:0]   w_data;
  logic                a_valid, a_ready;
  logic [DATA_W-1:0]   a_data;
  logic                pin_valid, pin_ready;
  logic [DATA_W-1:0]   pin_data;
  logic                pout_valid, pout_ready;
  logic [DATA_W-1:0]   pout_data;
  logic [DATA_W-1:0]   mac_a, mac_w, mac_sum;
  logic                mac_en;
  logic [2*DATA_W-1:0] mac_out = '0;
  logic                busy, done, cfg_err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [DATA_W-1:0] wv [FILT_MAX];
  logic [DATA_W-1:0] av [IFMAP_MAX];
  logic [DATA_W-1:0] pv [IFMAP_MAX];

  pe_conv_ctrl #(.DATA_W(DATA_W), .FILT_MAX(FILT_MAX), .IFMAP_MAX(IFMAP_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .filt_len(filt_len), .ifmap_len(ifmap_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pin_valid(pin_valid), .pin_ready(pin_ready), .pin_data(pin_data),
    .pout_valid(pout_valid), .pout_ready(pout_ready), .pout_data(pout_data),
    .mac_a(mac_a), .mac_w(mac_w), .mac_sum(mac_sum), .mac_en(mac_en), .mac_out(mac_out),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered MAC: product plus sum, result visible the cycle after mac_en.
  always @(posedge clk) begin
    if (mac_en) mac_out <= (2*DATA_W)'(mac_a) * (2*DATA_W)'(mac_w) + (2*DATA_W)'(mac_sum);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    filt_len   = '0;
    ifmap_len  = '0;
    w_valid    = 1'b0;
    w_data     = '0;
    a_valid    = 1'b0;
    a_data     = '0;
    pin_valid  = 1'b0;
    pin_data   = '0;
    pout_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ctrl"},
             32'({w_ready, a_ready, pin_ready, pout_valid, mac_en, busy, done, cfg_err}), 32'(0));
    check_eq({tag, "_data"}, 32'(pout_data | mac_a | mac_w | mac_sum), 32'(0));
  endtask

  task automatic cfg_try(input int f, input int i);
    @(negedge clk);
    start     = 1'b1;
    filt_len  = FLEN_W'(f);
    ifmap_len = ILEN_W'(i);
    @(negedge clk);
    start = 1'b0;
    check_eq($sformatf("cfg_err_%0d_%0d", f, i), 32'(cfg_err), 32'(1));
    check_eq("cfg_busy", 32'(busy), 32'(0));
    @(negedge clk);
    check_eq("cfg_busy_hold", 32'(busy), 32'(0));
  endtask

  // mode 0: full throughput, 1: random bubbles/back-pressure, 2: pout_ready low 5 cycles per window.
  // abort_win >= 0 asserts rst during the MAC phase of that window.
  task automatic run_conv(input int s, input int wn, input int mode, input int abort_win);
    int nwin = wn - s + 1;
    int wi = 0, ai = 0, pi = 0, oi = 0;
    int busy_cyc = 0, en_cyc = 0, exp_en = 0, stall = 0, cyc = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] held = '0;
    bit holding = 0, fin = 0, aborted = 0;

    for (int j = 0; j < nwin; j++) begin
      acc = pv[j];
      for (int k = 0; k < s; k++) begin
        acc = acc + DATA_W'(wv[k] * av[j+k]);
        if (!SKIP || k == 0 || av[j+k] != '0) exp_en++;
      end
      exp_q.push_back(acc);
    end

    while (!fin && !aborted && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start     = (cyc == 1);
      filt_len  = FLEN_W'(s);
      ifmap_len = ILEN_W'(wn);
      if (cyc == 2) check_eq("cfg_clear", 32'(cfg_err), 32'(0));
      if (busy) busy_cyc++;
      if (mac_en) en_cyc++;
      if (done) fin = 1;
      if (abort_win >= 0 && pi == abort_win + 1 && mac_en) begin
        aborted = 1;
      end else begin
        if (pout_valid) begin
          if (holding) check_eq("hold_data", 32'(pout_data), 32'(held));
          check_eq("emit_mac_en", 32'(mac_en), 32'(0));
          case (mode)
            0:       pout_ready = 1'b1;
            1:       pout_ready = 1'($urandom % 2);
            default: pout_ready = (stall >= 5);
          endcase
          stall++;
          if (pout_ready) begin
            if (oi < exp_q.size()) check_eq($sformatf("pout[%0d]", oi), 32'(pout_data), 32'(exp_q[oi]));
            else check_eq("extra_pout", 32'(1), 32'(0));
            oi++;
            holding = 0;
            stall   = 0;
          end else begin
            holding = 1;
            held    = pout_data;
          end
        end else begin
          pout_ready = 1'($urandom % 2);
          holding    = 0;
        end
        w_valid = (wi < s) && (mode != 1 || $urandom % 4 != 0);
        w_data  = (wi < s) ? wv[wi] : '0;
        if (w_valid && w_ready) wi++;
        a_valid = (ai < wn) && (mode != 1 || $urandom % 4 != 0);
        a_data  = (ai < wn) ? av[ai] : '0;
        if (a_valid && a_ready) ai++;
        pin_valid = (pi < nwin) && (mode != 1 || $urandom % 4 != 0);
        pin_data  = (pi < nwin) ? pv[pi] : '0;
        if (pin_valid && pin_ready) pi++;
      end
    end

    idle_inputs();
    if (aborted) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("abort");
    end else begin
      check_eq("run_finished", 32'(fin), 32'(1));
      check_eq("pout_count", 32'(oi), 32'(nwin));
      check_eq("mac_en_cycles", 32'(en_cyc), 32'(exp_en));
      if (mode == 0) check_eq("busy_cycles", 32'(busy_cyc), 32'(s + wn + nwin * (s + 2) + 1));
      @(negedge clk);
      check_eq("done_pulse", 32'(done), 32'(0));
      check_eq("idle_after_done", 32'(busy), 32'(0));
    end
  endtask

  task automatic fill_random(input int s, input int wn);
    for (int k = 0; k < s; k++) wv[k] = DATA_W'($urandom);
    for (int i = 0; i < wn; i++) begin
      av[i] = ($urandom % 4 == 0) ? '0 : DATA_W'($urandom);
      pv[i] = DATA_W'($urandom);
    end
  endtask

  initial begin
    int s, wn;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    for (int k = 0; k < 3; k++) wv[k] = DATA_W'(k + 1);
    for (int i = 0; i < 5; i++) av[i] = DATA_W'(i + 1);
    pv[0] = 16'd0; pv[1] = 16'd10; pv[2] = 16'd100;
    run_conv(3, 5, 0, -1);

    wv[0] = 16'hFFFF; av[0] = 16'hFFFF; pv[0] = 16'd2;
    run_conv(1, 1, 0, -1);

    cfg_try(4, 3);
    cfg_try(0, 3);
    cfg_try(9, 9);
    cfg_try(2, 33);
    fill_random(3, 4);
    run_conv(3, 4, 0, -1);

    fill_random(2, 4);
    run_conv(2, 4, 2, -1);

    fill_random(3, 6);
    run_conv(3, 6, 0, 1);
    fill_random(3, 6);
    run_conv(3, 6, 1, -1);

    wv[0] = 16'd1; wv[1] = 16'd1;
    av[0] = 16'd3; av[1] = 16'd0; av[2] = 16'd0; av[3] = 16'd4;
    pv[0] = 16'd7; pv[1] = 16'd20; pv[2] = 16'd300;
    run_conv(2, 4, 0, -1);

    for (int r = 0; r < 20; r++) begin
      s  = int'($urandom_range(1, FILT_MAX));
      wn = int'($urandom_range(s, IFMAP_MAX));
      fill_random(s, wn);
      run_conv(s, wn, (r % 3 == 0) ? 0 : 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
